pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port de_valid, input, 1: decode holds a real instruction this cycle.
REQ-004 SHALL have ports de_rs and de_rt, input, 5 each: source register numbers in decode.
REQ-005 SHALL have ports de_use_rs and de_use_rt, input, 1 each: decode reads rs / rt.
REQ-006 SHALL have port de_wen, input, 1: decode instruction writes a register.
REQ-007 SHALL have port de_dest, input, 5: destination register of the decode instruction.
REQ-008 SHALL have port de_is_load, input, 1: decode instruction is LW.
REQ-009 SHALL have port de_is_br, input, 1: decode instruction is a branch, J, JAL or JR.
REQ-010 SHALL have port stall, output, 1: freeze fetch and decode registers.
REQ-011 SHALL have port exe_bubble, output, 1: load a NOP into EXE this cycle (wen=0, dramwen=0).
REQ-012 SHALL have ports fwd_rs_sel and fwd_rt_sel, output, 2 each: 0=regfile, 1=EXE result, 2=MEM result, 3=WB result.
REQ-013 SHALL have port br_busy, output, 1: branch-wait sequence in progress.
REQ-014 SHALL have parameter BR_WAIT, default 3, meaning stall cycles after an accepted control-transfer instruction.

Function
REQ-015 SHALL keep a shadow pipeline of three entries (EXE, MEM, WB), each holding {valid, wen, dest, is_load}.
REQ-016 Each cycle, WB SHALL take MEM and MEM SHALL take EXE, unconditionally.
REQ-017 EXE SHALL take the decode fields when de_valid=1 and stall=0; otherwise EXE SHALL become invalid (bubble).
REQ-018 A load-use hazard SHALL exist when all of the following hold: EXE.valid, EXE.is_load, EXE.wen, EXE.dest!=0, and (de_use_rs & de_rs==EXE.dest) or (de_use_rt & de_rt==EXE.dest).
REQ-019 A load-use hazard SHALL assert stall and exe_bubble combinationally for exactly one cycle; on the next cycle the load is in MEM and is forwarded with select 2.
REQ-020 Forwarding for each source SHALL use the first match in priority order EXE, then MEM, then WB, where a match is valid & wen & dest==src & dest!=0.
REQ-021 Forwarding SHALL select 0 for register 0, for an unused source, and for no match.
REQ-022 Forwarding SHALL never select EXE for a load; the hazard stall covers that case.
REQ-023 The branch FSM SHALL have two states, IDLE and WAIT, with a counter of width clog2(BR_WAIT+1).
REQ-024 In IDLE, when de_valid & de_is_br & no load-use hazard, the FSM SHALL go to WAIT and load the counter with BR_WAIT.
REQ-025 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL go to IDLE when the counter reaches 1.
REQ-026 In WAIT, stall=1, exe_bubble=1 and br_busy=1.
REQ-027 A control-transfer instruction SHALL itself issue to EXE on the cycle it is accepted.
REQ-028 New de_is_br inputs SHALL be ignored while in WAIT.
REQ-029 When a load-use hazard and de_is_br occur together, the load stall SHALL take precedence; the branch is accepted on the following cycle.
REQ-030 stall SHALL equal (load-use hazard) OR (state==WAIT).
REQ-031 All outputs SHALL be combinational from state and inputs, with zero latency.

Reset
REQ-032 reset SHALL clear all shadow valid bits, set the FSM to IDLE and clear the counter, immediately and asynchronously.
REQ-033 During reset, outputs SHALL be stall=0, exe_bubble=0, br_busy=0, fwd_*_sel=0.
REQ-034 Reset asserted mid-WAIT SHALL abort the sequence; no residual stall is allowed after release.

Structure
REQ-035 The forwarding-select encodings, FSM state encodings and the BR_WAIT default SHALL reside in the shared CPU package alongside the ALU op codes.
REQ-036 The block SHALL contain one sub-module, fwd_select, instantiated once per source, which computes the priority match.

Verification
REQ-037 Hazard stall: LW $5 followed by ADDU $6,$5,$5 -> stall=1 and exe_bubble=1 for one cycle, then fwd_rs_sel=2 and fwd_rt_sel=2.
REQ-038 Forwarding priority: ADDIU $3, then ADDIU $3, then ADDU $4,$3,$0 -> fwd_rs_sel=1 (EXE), not 2.
REQ-039 Register zero: ADDIU $0 followed by ADDU using $0 -> fwd_*_sel=0 and stall=0.
REQ-040 Branch wait: BEQ with BR_WAIT=3 -> stall=1 and br_busy=1 for exactly 3 cycles, then IDLE.
REQ-041 Simultaneous events: LW $2 followed by BNE $2,$0 -> 1 load-stall cycle, then 3 WAIT cycles (4 stall cycles total).
REQ-042 Reset mid-operation: assert reset in the second WAIT cycle -> all outputs 0 immediately, and stall=0 after release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU definitions: ALU op codes, forwarding selects, branch-wait FSM states
// and the shadow-pipeline entry used by the hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef enum logic {
    BR_ST_IDLE = 1'b0,
    BR_ST_WAIT = 1'b1
  } br_state_e;

  localparam int BR_WAIT_DEFAULT = 3;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic [4:0] dest;
    logic       is_load;
  } shadow_t;

  // Register 0 is hardwired, so a write to it never produces a value worth forwarding.
  function automatic logic shadow_hit(input shadow_t e, input logic [4:0] src);
    return e.valid && e.wen && (e.dest == src) && (e.dest != 5'd0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Priority forwarding match for one decode source operand: EXE, then MEM, then WB.
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       use_src,
  input  logic [4:0] src,
  input  shadow_t    exe,
  input  shadow_t    mem,
  input  shadow_t    wb,
  output fwd_sel_e   sel
);

  always_comb begin
    sel = FWD_RF;
    if (use_src && (src != 5'd0)) begin
      // A load in EXE has no data yet; the load-use stall holds decode until it reaches MEM.
      if (shadow_hit(exe, src))      sel = exe.is_load ? FWD_RF : FWD_EXE;
      else if (shadow_hit(mem, src)) sel = FWD_MEM;
      else if (shadow_hit(wb, src))  sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: shadow pipeline, load-use stall, operand forwarding selects
// and a fixed-length branch-wait sequence.
//
// state      | meaning
// BR_ST_IDLE | normal issue; a control transfer may be accepted
// BR_ST_WAIT | counting down BR_WAIT stall cycles after an accepted control transfer
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BR_WAIT = BR_WAIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       de_valid,
  input  logic [4:0] de_rs,
  input  logic [4:0] de_rt,
  input  logic       de_use_rs,
  input  logic       de_use_rt,
  input  logic       de_wen,
  input  logic [4:0] de_dest,
  input  logic       de_is_load,
  input  logic       de_is_br,
  output logic       stall,
  output logic       exe_bubble,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       br_busy
);

  localparam int CNT_W = $clog2(BR_WAIT + 1);

  shadow_t          exe_q, exe_d;
  shadow_t          mem_q, mem_d;
  shadow_t          wb_q,  wb_d;
  br_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  fwd_sel_e         rs_sel, rt_sel;

  always_comb begin
    load_use = 1'b0;
    if (exe_q.is_load && shadow_hit(exe_q, exe_q.dest)) begin
      load_use = (de_use_rs && (de_rs == exe_q.dest)) ||
                 (de_use_rt && (de_rt == exe_q.dest));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_busy = 1'b0;
    case (state_q)
      BR_ST_IDLE: begin
        // Load stall wins; the branch is re-presented and accepted next cycle.
        if (de_valid && de_is_br && !load_use) begin
          state_d = BR_ST_WAIT;
          cnt_d   = CNT_W'(BR_WAIT);
        end
      end
      BR_ST_WAIT: begin
        br_busy = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = BR_ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = BR_ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall      = load_use || (state_q == BR_ST_WAIT);
  assign exe_bubble = stall;

  always_comb begin
    mem_d = exe_q;
    wb_d  = mem_q;
    exe_d = '0;
    if (de_valid && !stall) begin
      exe_d.valid   = 1'b1;
      exe_d.wen     = de_wen;
      exe_d.dest    = de_dest;
      exe_d.is_load = de_is_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_q   <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= BR_ST_IDLE;
      cnt_q   <= '0;
    end else begin
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  fwd_select u_fwd_rs (
    .use_src (de_use_rs),
    .src     (de_rs),
    .exe     (exe_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (rs_sel)
  );

  fwd_select u_fwd_rt (
    .use_src (de_use_rt),
    .src     (de_rt),
    .exe     (exe_q),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (rt_sel)
  );

  assign fwd_rs_sel = rs_sel;
  assign fwd_rt_sel = rt_sel;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use stall, forwarding priority,
// register zero, branch wait, load+branch interaction and reset mid-wait.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       de_valid;
  logic [4:0] de_rs, de_rt;
  logic       de_use_rs, de_use_rt;
  logic       de_wen;
  logic [4:0] de_dest;
  logic       de_is_load, de_is_br;
  logic       stall, exe_bubble, br_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.BR_WAIT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .de_valid   (de_valid),
    .de_rs      (de_rs),
    .de_rt      (de_rt),
    .de_use_rs  (de_use_rs),
    .de_use_rt  (de_use_rt),
    .de_wen     (de_wen),
    .de_dest    (de_dest),
    .de_is_load (de_is_load),
    .de_is_br   (de_is_br),
    .stall      (stall),
    .exe_bubble (exe_bubble),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .br_busy    (br_busy)
  );

  // Expected output vector: {stall, exe_bubble, br_busy, fwd_rs_sel, fwd_rt_sel}
  function automatic logic [6:0] ex(input logic s, input logic b, input logic y,
                                    input logic [1:0] rs, input logic [1:0] rt);
    return {s, b, y, rs, rt};
  endfunction

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {stall, exe_bubble, br_busy, fwd_rs_sel, fwd_rt_sel};
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed={st,bub,busy,rs,rt}=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic de(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                    input logic urs, input logic urt, input logic wen,
                    input logic [4:0] dest, input logic ld, input logic br);
    de_valid   = v;
    de_rs      = rs;
    de_rt      = rt;
    de_use_rs  = urs;
    de_use_rt  = urt;
    de_wen     = wen;
    de_dest    = dest;
    de_is_load = ld;
    de_is_br   = br;
  endtask

  task automatic nop();
    de(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // Reset with a busy-looking decode stage: outputs must still be quiet.
    reset = 1'b1;
    de(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    #2 chk("reset_outputs", ex(0, 0, 0, 0, 0));

    // Load-use: LW $5,0($1) then ADDU $6,$5,$5
    cyc(); reset = 1'b0;
    de(1, 5'd1, 5'd5, 1, 0, 1, 5'd5, 1, 0);
    #2 chk("lw_issue", ex(0, 0, 0, 0, 0));
    cyc(); de(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0, 0);
    #2 chk("lu_stall", ex(1, 1, 0, 0, 0));
    cyc();
    #2 chk("lu_fwd_mem", ex(0, 0, 0, 2, 2));
    cyc(); nop();
    #2 chk("lu_after_nop", ex(0, 0, 0, 0, 0));
    cyc(); cyc(); cyc();

    // Priority: ADDIU $3 twice, then consumers see EXE, MEM, WB in turn
    de(1, 5'd0, 5'd3, 1, 0, 1, 5'd3, 0, 0);
    #2 chk("addiu3_a", ex(0, 0, 0, 0, 0));
    cyc(); de(1, 5'd0, 5'd3, 1, 0, 1, 5'd3, 0, 0);
    cyc(); de(1, 5'd3, 5'd0, 1, 1, 1, 5'd4, 0, 0);
    #2 chk("prio_exe", ex(0, 0, 0, 1, 0));
    cyc(); de(1, 5'd3, 5'd3, 1, 1, 1, 5'd5, 0, 0);
    #2 chk("prio_mem", ex(0, 0, 0, 2, 2));
    cyc(); de(1, 5'd3, 5'd3, 1, 0, 1, 5'd7, 0, 0);
    #2 chk("prio_wb_rt_unused", ex(0, 0, 0, 3, 0));
    cyc(); nop(); cyc(); cyc(); cyc();

    // Register zero: ADDIU $0, LW $0, then ADDU $2,$0,$0
    de(1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 0, 0);
    cyc(); de(1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 1, 0);
    #2 chk("r0_after_addiu", ex(0, 0, 0, 0, 0));
    cyc(); de(1, 5'd0, 5'd0, 1, 1, 1, 5'd2, 0, 0);
    #2 chk("r0_no_stall_no_fwd", ex(0, 0, 0, 0, 0));
    cyc(); nop(); cyc(); cyc(); cyc();

    // Branch wait: BEQ $1,$2 held in decode (re-presented br ignored during WAIT)
    de(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1);
    #2 chk("beq_accept", ex(0, 0, 0, 0, 0));
    cyc(); #2 chk("beq_wait1", ex(1, 1, 1, 0, 0));
    cyc(); #2 chk("beq_wait2", ex(1, 1, 1, 0, 0));
    cyc(); #2 chk("beq_wait3", ex(1, 1, 1, 0, 0));
    cyc(); nop();
    #2 chk("beq_idle", ex(0, 0, 0, 0, 0));
    cyc(); #2 chk("beq_idle2", ex(0, 0, 0, 0, 0));
    cyc(); cyc();

    // LW $2 then BNE $2,$0: load stall first, branch accepted next cycle
    de(1, 5'd1, 5'd2, 1, 0, 1, 5'd2, 1, 0);
    cyc(); de(1, 5'd2, 5'd0, 1, 1, 0, 5'd0, 0, 1);
    #2 chk("lb_load_stall", ex(1, 1, 0, 0, 0));
    cyc(); #2 chk("lb_accept", ex(0, 0, 0, 2, 0));
    cyc(); #2 chk("lb_wait1_wb", ex(1, 1, 1, 3, 0));
    cyc(); #2 chk("lb_wait2", ex(1, 1, 1, 0, 0));
    cyc(); #2 chk("lb_wait3", ex(1, 1, 1, 0, 0));
    cyc(); nop();
    #2 chk("lb_idle", ex(0, 0, 0, 0, 0));
    cyc(); cyc(); cyc();

    // Reset asserted during the second WAIT cycle
    de(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1);
    cyc(); #2 chk("rst_wait1", ex(1, 1, 1, 0, 0));
    cyc(); #2 chk("rst_wait2", ex(1, 1, 1, 0, 0));
    #1 reset = 1'b1;
    #1 chk("rst_async_clear", ex(0, 0, 0, 0, 0));
    cyc(); reset = 1'b0; nop();
    #2 chk("rst_release", ex(0, 0, 0, 0, 0));
    cyc(); #2 chk("rst_no_residual1", ex(0, 0, 0, 0, 0));
    cyc(); #2 chk("rst_no_residual2", ex(0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
